sm83_alu_seq: RTL

- Micro-sequencer that sits between the SM83 decoder and the 4-bit-core ALU.
- Accepts one 8-bit ALU/CB operation per request and drives the ALU's load, output-enable, mux, R/S/V, negate, carry and shift strobes over a fixed step sequence.
- Samples the ALU bus, carry and zero outputs, then returns the 8-bit result and Z/N/H/C flags with a one-cycle response pulse.

---
 rtl/sm83_alu_seq.sv | 328 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: steps the SM83 4-bit ALU core through one 8-bit ALU/CB operation per request.
// Define SM83_ALU_SEQ_SWAP_EN to add the three-step SWAP sequence; otherwise SWAP decodes as illegal.
module sm83_alu_seq #(
    parameter int ALU_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4:0]             req_op,
    input  logic [2*ALU_WIDTH-1:0] req_a,
    input  logic [2*ALU_WIDTH-1:0] req_b,
    input  logic [2:0]             req_bit,
    input  logic [3:0]             req_flags,
    output logic                   rsp_valid,
    output logic [2*ALU_WIDTH-1:0] rsp_result,
    output logic [3:0]             rsp_flags,
    output logic [2*ALU_WIDTH-1:0] alu_din,
    input  logic [2*ALU_WIDTH-1:0] alu_dout,
    input  logic                   alu_carry,
    input  logic                   alu_zero,
    input  logic                   alu_shift_dbh,
    input  logic                   alu_shift_dbl,
    output logic                   alu_load_a,
    output logic                   alu_load_b,
    output logic                   alu_load_b_lq,
    output logic                   alu_load_b_zero,
    output logic                   alu_shift_l,
    output logic                   alu_shift_r,
    output logic                   alu_shift_in,
    output logic                   alu_carry_in,
    output logic [2:0]             alu_bsel,
    output logic                   alu_result_oe,
    output logic                   alu_shift_oe,
    output logic                   alu_op_a_oe,
    output logic                   alu_op_b_oe,
    output logic                   alu_bs_oe,
    output logic                   alu_no_carry_out,
    output logic                   alu_force_carry,
    output logic                   alu_ignore_carry,
    output logic                   alu_negate,
    output logic                   alu_mux,
    output logic                   alu_op_b_mux
);

    localparam int W = 2 * ALU_WIDTH;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADC  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SBC  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_CP   = 5'd7;
    localparam logic [4:0] OP_INC  = 5'd8;
    localparam logic [4:0] OP_DEC  = 5'd9;
    localparam logic [4:0] OP_RLC  = 5'd10;
    localparam logic [4:0] OP_RRC  = 5'd11;
    localparam logic [4:0] OP_RL   = 5'd12;
    localparam logic [4:0] OP_RR   = 5'd13;
    localparam logic [4:0] OP_SLA  = 5'd14;
    localparam logic [4:0] OP_SRA  = 5'd15;
    localparam logic [4:0] OP_SWAP = 5'd16;
    localparam logic [4:0] OP_SRL  = 5'd17;
    localparam logic [4:0] OP_BIT  = 5'd18;
    localparam logic [4:0] OP_RES  = 5'd19;
    localparam logic [4:0] OP_SET  = 5'd20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LDA,
        ST_LDB,
        ST_LO,
        ST_HI,
        ST_SHF,
        ST_ILL,
        ST_LQ,
        ST_OUT
    } state_e;

    state_e         state_q, state_d, first_state;
    logic [4:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [2:0]     bit_q;
    logic [3:0]     flags_q;
    logic           hc_q, hc_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_result_q, rsp_result_d;
    logic [3:0]     rsp_flags_q, rsp_flags_d;

    logic           accept;
    logic           c_in;
    logic           ctl_r, ctl_s, ctl_v, ctl_neg, lo_cin, hi_cin;
    logic           shf_left, shf_in;
    logic [3:0]     hi_flags;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign c_in       = flags_q[0];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

    always_comb begin
        first_state = ST_ILL;
        case (req_op) inside
            [OP_ADD:OP_DEC], [OP_BIT:OP_SET]: first_state = ST_LDA;
            [OP_RLC:OP_SRA], OP_SRL:          first_state = ST_SHF;
`ifdef SM83_ALU_SEQ_SWAP_EN
            OP_SWAP:                          first_state = ST_LDA;
`else
            OP_SWAP:                          first_state = ST_ILL;
`endif
            default:                          first_state = ST_ILL;
        endcase
    end

    // R/S/V, negate and carry-in for the two nibble passes, keyed on the latched opcode.
    always_comb begin
        ctl_r   = 1'b0;
        ctl_s   = 1'b0;
        ctl_v   = 1'b0;
        ctl_neg = 1'b0;
        lo_cin  = 1'b0;
        hi_cin  = hc_q;
        case (op_q)
            OP_ADC:        lo_cin = c_in;
            OP_SUB, OP_CP: begin ctl_neg = 1'b1; lo_cin = 1'b1; end
            OP_SBC:        begin ctl_neg = 1'b1; lo_cin = ~c_in; end
            OP_INC:        lo_cin = 1'b1;
            OP_DEC:        ctl_neg = 1'b1;
            OP_AND, OP_BIT: begin ctl_s = 1'b1; lo_cin = 1'b1; hi_cin = 1'b1; end
            OP_RES: begin
                ctl_s   = 1'b1;
                ctl_neg = 1'b1;
                lo_cin  = 1'b1;
                hi_cin  = 1'b1;
            end
            OP_OR, OP_SET: begin ctl_r = 1'b1; ctl_v = 1'b1; hi_cin = 1'b0; end
            OP_XOR:        begin ctl_r = 1'b1; hi_cin = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        shf_left = (op_q == OP_RLC) || (op_q == OP_RL) || (op_q == OP_SLA);
        case (op_q)
            OP_RLC, OP_SRA: shf_in = alu_shift_dbh;
            OP_RRC:         shf_in = alu_shift_dbl;
            OP_RL, OP_RR:   shf_in = c_in;
            default:        shf_in = 1'b0;
        endcase
    end

    // Kept apart from the strobe decode so the ALU's dbh/dbl never feed back into alu_din logic.
    assign alu_shift_in = !reset && (state_q == ST_SHF) && shf_in;

    always_comb begin
        hi_flags = flags_q;
        case (op_q)
            OP_ADD, OP_ADC:        hi_flags = {alu_zero, 1'b0, hc_q, alu_carry};
            OP_INC:                hi_flags = {alu_zero, 1'b0, hc_q, c_in};
            OP_SUB, OP_SBC, OP_CP: hi_flags = {alu_zero, 1'b1, ~hc_q, ~alu_carry};
            OP_DEC:                hi_flags = {alu_zero, 1'b1, ~hc_q, c_in};
            OP_AND:                hi_flags = {alu_zero, 3'b010};
            OP_OR, OP_XOR:         hi_flags = {alu_zero, 3'b000};
            OP_BIT:                hi_flags = {alu_zero, 2'b01, c_in};
            default:               hi_flags = flags_q;
        endcase
    end

    always_comb begin
        alu_din          = '0;
        alu_load_a       = 1'b0;
        alu_load_b       = 1'b0;
        alu_load_b_lq    = 1'b0;
        alu_load_b_zero  = 1'b0;
        alu_shift_l      = 1'b0;
        alu_shift_r      = 1'b0;
        alu_carry_in     = 1'b0;
        alu_bsel         = 3'd0;
        alu_result_oe    = 1'b0;
        alu_shift_oe     = 1'b0;
        alu_op_a_oe      = 1'b0;
        alu_op_b_oe      = 1'b0;
        alu_bs_oe        = 1'b0;
        alu_no_carry_out = 1'b0;
        alu_force_carry  = 1'b0;
        alu_ignore_carry = 1'b0;
        alu_negate       = 1'b0;
        alu_mux          = 1'b0;
        alu_op_b_mux     = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_LDA: begin
                    alu_din      = a_q;
                    alu_shift_oe = 1'b1;
                    alu_load_a   = 1'b1;
                end
                ST_LDB: begin
                    if (op_q == OP_INC || op_q == OP_DEC) begin
                        alu_load_b_zero = 1'b1;
                    end else if (op_q == OP_BIT || op_q == OP_RES || op_q == OP_SET) begin
                        alu_bs_oe  = 1'b1;
                        alu_load_b = 1'b1;
                        alu_bsel   = bit_q;
                    end else begin
                        alu_din      = b_q;
                        alu_shift_oe = 1'b1;
                        alu_load_b   = 1'b1;
                    end
                end
                ST_LO: begin
                    alu_no_carry_out = ctl_r;
                    alu_force_carry  = ctl_s;
                    alu_ignore_carry = ctl_v;
                    alu_negate       = ctl_neg;
                    alu_carry_in     = lo_cin;
                end
                ST_HI: begin
                    alu_no_carry_out = ctl_r;
                    alu_force_carry  = ctl_s;
                    alu_ignore_carry = ctl_v;
                    alu_negate       = ctl_neg;
                    alu_carry_in     = hi_cin;
                    alu_mux          = 1'b1;
                    alu_op_b_mux     = 1'b1;
                    alu_result_oe    = 1'b1;
                end
                ST_SHF: begin
                    alu_din      = a_q;
                    alu_shift_oe = 1'b1;
                    alu_shift_l  = shf_left;
                    alu_shift_r  = ~shf_left;
                end
`ifdef SM83_ALU_SEQ_SWAP_EN
                ST_LQ: begin
                    alu_mux       = 1'b1;
                    alu_op_a_oe   = 1'b1;
                    alu_load_b_lq = 1'b1;
                end
                ST_OUT: alu_op_b_oe = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        hc_d         = hc_q;
        rsp_valid_d  = 1'b0;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = first_state;
            ST_LDA: begin
                state_d = ST_LDB;
`ifdef SM83_ALU_SEQ_SWAP_EN
                if (op_q == OP_SWAP) state_d = ST_LQ;
`endif
            end
            ST_LDB: state_d = ST_LO;
            ST_LO: begin
                hc_d    = alu_carry;
                state_d = ST_HI;
            end
            ST_HI: begin
                state_d      = ST_IDLE;
                rsp_valid_d  = 1'b1;
                rsp_result_d = (op_q == OP_CP || op_q == OP_BIT) ? a_q : alu_dout;
                rsp_flags_d  = hi_flags;
            end
            ST_SHF: begin
                state_d      = ST_IDLE;
                rsp_valid_d  = 1'b1;
                rsp_result_d = alu_dout;
                rsp_flags_d  = {alu_zero, 2'b00, shf_left ? alu_shift_dbh : alu_shift_dbl};
            end
`ifdef SM83_ALU_SEQ_SWAP_EN
            ST_LQ: state_d = ST_OUT;
            ST_OUT: begin
                state_d      = ST_IDLE;
                rsp_valid_d  = 1'b1;
                rsp_result_d = alu_dout;
                rsp_flags_d  = {alu_zero, 3'b000};
            end
`endif
            ST_ILL: begin
                state_d      = ST_IDLE;
                rsp_valid_d  = 1'b1;
                rsp_result_d = a_q;
                rsp_flags_d  = flags_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            bit_q        <= '0;
            flags_q      <= '0;
            hc_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            hc_q         <= hc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            if (accept) begin
                op_q    <= req_op;
                a_q     <= req_a;
                b_q     <= req_b;
                bit_q   <= req_bit;
                flags_q <= req_flags;
            end
        end
    end

endmodule
